// File: rtl/sipo_pkg.sv
// Shared types and build-mode constants for the serial-in/parallel-out receive controller.
// Build option: define PARITY_CHECK_EN to add a trailing even-parity bit per frame.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } sipo_state_t;

`ifdef PARITY_CHECK_EN
    localparam bit PARITY_MODE = 1'b1;
`else
    localparam bit PARITY_MODE = 1'b0;
`endif

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit left shift register: new bits enter at the LSB, so the first bit ends up at the MSB.
module sipo_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_data <= '0;
        end else if (shift_en) begin
            r_data <= {r_data[WIDTH-2:0], bit_in};
        end
    end

    assign data = r_data;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller: collects WIDTH qualified serial bits, then hands the word over a valid/ready buffer.
// Build option: PARITY_CHECK_EN adds a parity-bit phase and the par_err pulse (otherwise par_err is 0).
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             serial_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);

    sipo_state_t      r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hold;
    logic             r_valid;
    logic             r_overrun;
    logic             r_par_err;

    logic [WIDTH-1:0] w_shreg;
    logic             w_clr;
    logic             w_shift;
    logic             w_load;
    logic             w_last_bit;

    // A start in any collecting phase (or in IDLE) clears the core; DONE ignores start.
    assign w_clr      = start && (r_state != DONE);
    assign w_shift    = (r_state == SHIFT) && bit_en && !start;
    assign w_last_bit = (r_count == CNT_W'(WIDTH - 1));
    assign w_load     = (r_state == DONE) && (!r_valid || out_ready);

    sipo_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .shift_en(w_shift),
        .bit_in  (serial_in),
        .data    (w_shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_par_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_count <= '0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        r_count <= '0;
                    end else if (bit_en) begin
                        r_count <= r_count + CNT_W'(1);
                        if (w_last_bit) begin
`ifdef PARITY_CHECK_EN
                            r_state <= PAR;
`else
                            r_state <= DONE;
`endif
                        end
                    end
                end
`ifdef PARITY_CHECK_EN
                PAR: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_count <= '0;
                    end else if (bit_en) begin
                        if ((^w_shreg) ^ serial_in) begin
                            r_par_err <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
`endif
                DONE: begin
                    r_state   <= IDLE;
                    r_overrun <= !w_load;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output buffer: a load wins over a same-cycle consume, so back-to-back words keep valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_hold  <= w_shreg;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign parallel_out = r_hold;
    assign out_valid    = r_valid;
    assign busy         = (r_state != IDLE);
    assign overrun      = r_overrun;
    assign par_err      = r_par_err;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl: frame-level reference model, directed frames, then random traffic.
module tb_sipo_rx_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             serial_in = 1'b0;
    logic             bit_en = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic             par_err;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

`ifdef PARITY_CHECK_EN
    localparam bit withParity = 1'b1;
`else
    localparam bit withParity = 1'b0;
`endif

    sipo_rx_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .serial_in   (serial_in),
        .bit_en      (bit_en),
        .parallel_out(parallel_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    // Reference model: frame in progress, bits gathered so far, completed word awaiting hand-off.
    bit inFrame = 0;
    bit awaitParity = 0;
    bit wordReady = 0;
    int bitsGot = 0;
    int word = 0;
    int held = 0;
    bit heldValid = 0;
    bit expOverrun = 0;
    bit expParErr = 0;

    always @(posedge clk) begin
        bit wasReady;
        bit loaded;
        if (rst) begin
            inFrame = 0; awaitParity = 0; wordReady = 0; bitsGot = 0; word = 0;
            held = 0; heldValid = 0; expOverrun = 0; expParErr = 0;
        end else begin
            wasReady   = wordReady;
            loaded     = 0;
            expOverrun = 0;
            expParErr  = 0;
            if (wasReady) begin
                wordReady = 0;
                if (!heldValid || out_ready) begin
                    held = word;
                    loaded = 1;
                end else begin
                    expOverrun = 1;
                end
            end
            if (loaded) heldValid = 1;
            else if (heldValid && out_ready) heldValid = 0;

            if (inFrame) begin
                if (start) begin
                    bitsGot = 0; word = 0; awaitParity = 0;
                end else if (bit_en && awaitParity) begin
                    inFrame = 0; awaitParity = 0;
                    if ((($countones(word) + int'(serial_in)) % 2) != 0) expParErr = 1;
                    else wordReady = 1;
                end else if (bit_en) begin
                    word = ((word * 2) + int'(serial_in)) % (1 << WIDTH);
                    bitsGot++;
                    if (bitsGot == WIDTH) begin
                        if (withParity) awaitParity = 1;
                        else begin
                            inFrame = 0;
                            wordReady = 1;
                        end
                    end
                end
            end else if (!wasReady && start) begin
                inFrame = 1; bitsGot = 0; word = 0; awaitParity = 0;
            end
        end
    end

    task automatic compareOne(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            compareOne("model parallel_out", int'(parallel_out), held);
            compareOne("model out_valid", int'(out_valid), int'(heldValid));
            compareOne("model busy", int'(busy), int'(inFrame || wordReady));
            compareOne("model overrun", int'(overrun), int'(expOverrun));
            compareOne("model par_err", int'(par_err), int'(expParErr));
        end
    end

    task automatic applyStimulus(input logic s, input logic be, input logic si, input logic rdy);
        start     = s;
        bit_en    = be;
        serial_in = si;
        out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareOne(name, actual, expected);
    endtask

    // Sends a start and WIDTH data bits (plus parity when enabled); gap inserts idle cycles between bits.
    task automatic sendFrame(input logic [WIDTH-1:0] w, input bit gap, input bit badPar);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, w[i], 1'b0);
            if (gap) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        end
        if (withParity) applyStimulus(1'b0, 1'b1, (^w) ^ badPar, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkEn = 1'b1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset parallel_out", int'(parallel_out), 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Basic capture and consume.
        sendFrame(4'b1101, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("frame1 parallel_out", int'(parallel_out), 13);
        checkOutput("frame1 out_valid", int'(out_valid), 1);
        checkOutput("frame1 busy", int'(busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("consume out_valid", int'(out_valid), 0);

        // Overrun while 1101 is held.
        sendFrame(4'b1101, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        sendFrame(4'b0110, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("overrun pulse", int'(overrun), 1);
        checkOutput("overrun held word", int'(parallel_out), 13);
        checkOutput("overrun out_valid", int'(out_valid), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("overrun one cycle", int'(overrun), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Restart mid-frame, then a gapped frame.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        sendFrame(4'b0110, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restart parallel_out", int'(parallel_out), 6);
        checkOutput("restart overrun", int'(overrun), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame discards a held word and the partial frame.
        sendFrame(4'b1111, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset out_valid", int'(out_valid), 0);
        checkOutput("midreset parallel_out", int'(parallel_out), 0);
        sendFrame(4'b1010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fresh parallel_out", int'(parallel_out), 10);

        // Back-to-back: consume 1010 on the same cycle 0011 loads.
        sendFrame(4'b0011, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b parallel_out", int'(parallel_out), 3);
        checkOutput("b2b out_valid", int'(out_valid), 1);
        checkOutput("b2b overrun", int'(overrun), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b drained", int'(out_valid), 0);

        if (withParity) begin
            sendFrame(4'b1101, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("parity ok word", int'(parallel_out), 13);
            checkOutput("parity ok par_err", int'(par_err), 0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            sendFrame(4'b1101, 1'b0, 1'b1);
            checkOutput("parity bad pulse", int'(par_err), 1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("parity bad one cycle", int'(par_err), 0);
            checkOutput("parity bad out_valid", int'(out_valid), 0);
        end

        // Random traffic checked against the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus(logic'($urandom_range(0, 11) == 0), logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        checkEn = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
Frame controller that sequences a serial-in/parallel-out capture. On a start strobe it collects WIDTH qualified serial bits into an internal shift core and counts them. It then moves the completed word into an output holding register with a valid/ready handshake. It sits between a bit-level serial source and a word-level consumer, and reports busy, overrun and (optionally) parity status.

Parameters:
WIDTH, 4, data bits per frame (>=2)
CNT_W, $clog2(WIDTH+1), bit counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  frame start strobe, one cycle
serial_in  input  1  serial data bit
bit_en  input  1  qualifies serial_in as a valid bit this cycle
parallel_out  output  WIDTH  held output word, MSB = first received bit
out_valid  output  1  parallel_out holds an unconsumed word
out_ready  input  1  consumer accepts word when out_valid && out_ready
busy  output  1  state != IDLE
overrun  output  1  one-cycle pulse: completed word dropped, output buffer full
par_err  output  1  one-cycle pulse: parity mismatch, word dropped (PARITY_CHECK_EN only; else tied 0)

Behaviour:
- Reset (sync, active-high, clk and rst only): state=IDLE, count=0, shreg=0, parallel_out=0, out_valid=0, overrun=0, par_err=0. Reset overrides every other input in the same cycle. Reset mid-frame discards the partial frame and any held word.
- States: IDLE, SHIFT, PAR (only with macro), DONE.
- IDLE: bit_en ignored.
  - start=1 -> SHIFT, count=0, shreg=0.
- SHIFT: on bit_en, shreg <= {shreg[WIDTH-2:0], serial_in} and count++. The first bit ends up at the MSB.
  - When bit_en && count==WIDTH-1: -> PAR if macro enabled, else -> DONE.
  - Cycles without bit_en hold state, count and shreg.
  - start=1 in SHIFT (with or without bit_en) restarts: count=0, shreg=0, stay in SHIFT, bit not shifted. No output and no error flag.
- DONE (exactly one cycle), always -> IDLE.
  - Buffer free (out_valid==0, or out_ready==1 this cycle): parallel_out <= shreg, out_valid <= 1.
  - Buffer full: overrun pulses high for one cycle. The word is dropped; parallel_out and out_valid are unchanged.
- start in DONE is ignored. The next frame needs start in IDLE.
- Latency: a last bit_en on edge N gives state DONE after N. out_valid=1 and the new parallel_out are visible after edge N+1.
- Handshake: out_valid clears on an edge where out_valid && out_ready and no load occurs. A load in the same cycle keeps out_valid=1 with the new word. parallel_out is stable while out_valid && !out_ready.
- busy is combinational from state.
- overrun and par_err are registered pulses, never sticky.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined: after WIDTH data bits, the controller enters PAR and waits for one more bit_en.
  - Check: even parity over data bits plus parity bit, i.e. (^shreg ^ serial_in) must be 0.
  - Match -> DONE.
  - Mismatch -> par_err one-cycle pulse, word dropped, -> IDLE.
  - start in PAR restarts the frame, as in SHIFT.
- Undefined: PAR state and the parity logic are absent; par_err is driven 0.
- Port list is identical in both builds.

Decomposition:
- Shared package sipo_pkg holds:
  - state enum type sipo_state_t {IDLE, SHIFT, PAR, DONE};
  - parity-mode constant.
- One natural sub-module, sipo_shift_core: WIDTH-bit shift register with shift_en, sync clear and parallel read. The controller instantiates it and owns the FSM, counter, holding register and handshake.

Test Plan:
- WIDTH=4, start, bits 1,1,0,1 on consecutive bit_en, out_ready=0 -> after 2 edges past last bit: parallel_out=4'b1101, out_valid=1, busy=0. Then out_ready=1 for one cycle -> out_valid=0.
- Hold out_ready=0 with 1101 held; send frame 0,1,1,0 -> overrun pulses exactly one cycle; parallel_out stays 1101 and out_valid stays 1.
- Start, bits 1,0, then start, then 0,1,1,0 with idle gaps between bit_en -> parallel_out=4'b0110 and no overrun.
- rst asserted after 2 of 4 bits -> next edge: busy=0, out_valid=0, parallel_out=0. Fresh frame 1,0,1,0 -> parallel_out=4'b1010.
- Back-to-back: out_ready=1 on the same cycle DONE loads frame 2 (frame 1 pending) -> frame 1 consumed, parallel_out=frame 2, out_valid stays 1, no overrun.
- With PARITY_CHECK_EN:
  - data 1101 + parity 1 -> output 1101, par_err=0;
  - data 1101 + parity 0 -> par_err one pulse, out_valid stays 0.
